// File: rtl/blink_pkg.sv
// Shared types, reset constants and helpers for the blink scheduler.
package blink_pkg;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned BIT_SEL_RST = 7;
    localparam int unsigned OFFSET_RST  = 0;

    typedef enum logic [1:0] {
        StIdle,
        StSample,
        StEval,
        StCommit
    } state_e;

    // Ceiling log2, used to size index ports.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/blink_eval.sv
// Shared evaluator: modular add of snapshot and offset, bit select, enable gate.
module blink_eval
    import blink_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    localparam int unsigned BIT_W = clog2(CNT_W)
) (
    input  logic [CNT_W-1:0] snapshot,
    input  logic [CNT_W-1:0] offset,
    input  logic [BIT_W-1:0] bit_sel,
    input  logic             enable,
    output logic             bit_val
);

    logic [CNT_W-1:0] sum;

    always_comb begin
        sum     = snapshot + offset;
        bit_val = enable & sum[bit_sel];
    end

endmodule

// File: rtl/blink_scheduler.sv
// Time-multiplexed blink controller: one evaluator scans all channels per frame,
// and every channel output commits on the same edge.
module blink_scheduler
    import blink_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    localparam int unsigned CH_W  = clog2(NUM_CH),
    localparam int unsigned BIT_W = clog2(CNT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [BIT_W-1:0]  cfg_bit,
    input  logic [CNT_W-1:0]  cfg_offset,
    input  logic              cfg_enable,
    output logic [NUM_CH-1:0] blink_out,
    output logic              busy
);

    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

    state_e              state;
    logic [CH_W-1:0]     idx;
    logic [CNT_W-1:0]    snapshot;
    logic [NUM_CH-1:0]   shadow;
    logic [BIT_W-1:0]    bit_sel [NUM_CH];
    logic [CNT_W-1:0]    offset  [NUM_CH];
    logic [NUM_CH-1:0]   ch_en;
    logic                eval_bit;
    logic                cfg_write;

    // Out-of-range channel writes complete the handshake but touch nothing.
    assign cfg_write = cfg_valid && cfg_ready && (32'(cfg_ch) < NUM_CH);

    blink_eval #(
        .CNT_W (CNT_W)
    ) u_eval (
        .snapshot (snapshot),
        .offset   (offset[idx]),
        .bit_sel  (bit_sel[idx]),
        .enable   (ch_en[idx]),
        .bit_val  (eval_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            idx       <= '0;
            snapshot  <= '0;
            shadow    <= '0;
            blink_out <= '0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            ch_en     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                bit_sel[i] <= BIT_W'(BIT_SEL_RST);
                offset[i]  <= CNT_W'(OFFSET_RST);
            end
        end else begin
            if (cfg_write) begin
                bit_sel[cfg_ch] <= cfg_bit;
                offset[cfg_ch]  <= cfg_offset;
                ch_en[cfg_ch]   <= cfg_enable;
            end
            unique case (state)
                StIdle: begin
                    if (en) begin
                        state <= StSample;
                        busy  <= 1'b1;
                    end
                end
                StSample: begin
                    snapshot  <= count_in;
                    idx       <= '0;
                    state     <= StEval;
                    cfg_ready <= 1'b0;
                end
                StEval: begin
                    shadow[idx] <= eval_bit;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        state     <= StCommit;
                        cfg_ready <= 1'b1;
                    end else begin
                        idx <= idx + CH_W'(1);
                    end
                end
                StCommit: begin
                    blink_out <= shadow;
                    if (en) begin
                        state <= StSample;
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_scheduler.sv
// Directed bench for blink_scheduler: a 4-channel instance plus a 5-channel one
// for the out-of-range channel write.
module tb_blink_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] count_in;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [3:0]  cfg_bit;
    logic [15:0] cfg_offset;
    logic        cfg_enable;
    logic [3:0]  blink_out;
    logic        busy;

    logic        en2;
    logic [15:0] count2;
    logic        cfg_valid2;
    logic        cfg_ready2;
    logic [2:0]  cfg_ch2;
    logic [3:0]  cfg_bit2;
    logic [15:0] cfg_offset2;
    logic        cfg_enable2;
    logic [4:0]  blink_out2;
    logic        busy2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    blink_scheduler #(
        .NUM_CH (4),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .count_in   (count_in),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_bit    (cfg_bit),
        .cfg_offset (cfg_offset),
        .cfg_enable (cfg_enable),
        .blink_out  (blink_out),
        .busy       (busy)
    );

    blink_scheduler #(
        .NUM_CH (5),
        .CNT_W  (16)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .en         (en2),
        .count_in   (count2),
        .cfg_valid  (cfg_valid2),
        .cfg_ready  (cfg_ready2),
        .cfg_ch     (cfg_ch2),
        .cfg_bit    (cfg_bit2),
        .cfg_offset (cfg_offset2),
        .cfg_enable (cfg_enable2),
        .blink_out  (blink_out2),
        .busy       (busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full frame when positioned just after entering SAMPLE with en high.
    task automatic frame();
        repeat (6) tick();
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [3:0] b, input logic [15:0] off,
                             input logic e);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_bit    = b;
        cfg_offset = off;
        cfg_enable = e;
        tick();
        cfg_valid  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_b;
        rst = 1'b1; en = 1'b0; count_in = '0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_bit = '0; cfg_offset = '0; cfg_enable = 1'b0;
        en2 = 1'b0; count2 = '0;
        cfg_valid2 = 1'b0; cfg_ch2 = '0; cfg_bit2 = '0; cfg_offset2 = '0; cfg_enable2 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_blink", 32'(blink_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_blink2", 32'(blink_out2), 32'd0);

        // Reset mid-EVAL clears config and suppresses the commit.
        cfg_write(2'd0, 4'd0, 16'h0000, 1'b1);
        count_in = 16'h0001;
        en = 1'b1;
        tick();
        check("t1_sample_busy", 32'(busy), 32'd1);
        tick();
        check("t1_eval_ready", 32'(cfg_ready), 32'd0);
        rst = 1'b1;
        tick();
        tick();
        check("t1_rst_blink", 32'(blink_out), 32'd0);
        check("t1_rst_busy", 32'(busy), 32'd0);
        check("t1_rst_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;
        repeat (13) tick();
        check("t1_cleared", 32'(blink_out), 32'd0);
        en = 1'b0;
        wait_idle();

        // Basic enable on ch0, bit 7.
        cfg_write(2'd0, 4'd7, 16'h0000, 1'b1);
        count_in = 16'h0080;
        en = 1'b1;
        tick();
        repeat (5) tick();
        check("t2_pre_commit", 32'(blink_out), 32'd0);
        tick();
        check("t2_ch0_hi", 32'(blink_out), 32'b0001);
        count_in = 16'h007F;
        frame();
        check("t2_ch0_lo", 32'(blink_out), 32'b0000);

        // Offset wrap on ch1, written during SAMPLE.
        check("t3_ready_sample", 32'(cfg_ready), 32'd1);
        count_in = 16'hFFFF;
        cfg_write(2'd1, 4'd15, 16'h0001, 1'b1);
        repeat (5) tick();
        check("t3_wrap", 32'(blink_out), 32'b0001);
        count_in = 16'h7FFF;
        frame();
        check("t3_carry", 32'(blink_out), 32'b0011);

        // Stalled write held across EVAL, accepted in COMMIT.
        count_in = 16'h0004;
        tick();
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_bit = 4'd2; cfg_offset = 16'h0000; cfg_enable = 1'b1;
        check("t4_stall0", 32'(cfg_ready), 32'd0);
        tick();
        check("t4_stall1", 32'(cfg_ready), 32'd0);
        tick();
        check("t4_stall2", 32'(cfg_ready), 32'd0);
        tick();
        check("t4_stall3", 32'(cfg_ready), 32'd0);
        tick();
        check("t4_commit_ready", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        check("t4_not_yet", 32'(blink_out), 32'b0000);
        frame();
        check("t4_ch2_on", 32'(blink_out), 32'b0100);

        // en dropped at EVAL index 1: frame completes, then IDLE holds output.
        count_in = 16'h0080;
        tick();
        tick();
        en = 1'b0;
        tick();
        check("t5_still_eval", 32'(cfg_ready), 32'd0);
        tick();
        tick();
        check("t5_commit_busy", 32'(busy), 32'd1);
        check("t5_commit_hold", 32'(blink_out), 32'b0100);
        tick();
        check("t5_final", 32'(blink_out), 32'b0001);
        check("t5_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 20; i++) begin
            count_in = 16'($urandom);
            tick();
            check("t5_hold", {27'd0, busy, blink_out}, 32'b00001);
        end

        // Coherent commit: all channels on bit 0, count_in toggling with one phase slip.
        cfg_write(2'd0, 4'd0, 16'h0000, 1'b1);
        cfg_write(2'd1, 4'd0, 16'h0000, 1'b1);
        cfg_write(2'd2, 4'd0, 16'h0000, 1'b1);
        cfg_write(2'd3, 4'd0, 16'h0000, 1'b1);
        en = 1'b1;
        for (int t = 1; t <= 19; t++) begin
            count_in = (t <= 9) ? 16'((t + 1) % 2) : 16'(t % 2);
            tick();
            exp_b = (t < 7) ? 4'b0001 : ((t < 19) ? 4'b1111 : 4'b0000);
            check("t6_coherent", 32'(blink_out), 32'(exp_b));
        end
        en = 1'b0;
        wait_idle();

        // Out-of-range channel write on the 5-channel instance.
        count2 = 16'h0001;
        cfg_valid2 = 1'b1; cfg_ch2 = 3'd5; cfg_bit2 = 4'd0; cfg_offset2 = 16'h0000;
        cfg_enable2 = 1'b1;
        check("oor_ready", 32'(cfg_ready2), 32'd1);
        tick();
        cfg_valid2 = 1'b0;
        en2 = 1'b1;
        repeat (8) tick();
        check("oor_no_effect", 32'(blink_out2), 32'd0);
        cfg_valid2 = 1'b1; cfg_ch2 = 3'd4;
        tick();
        cfg_valid2 = 1'b0;
        repeat (6) tick();
        check("ch4_on", 32'(blink_out2), 32'b10000);
        en2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
